// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART RX controller: captures strobed bytes into a circular
// buffer and presents them on a first-word-fall-through valid/ready read port.
module uart_rx_fifo #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_Rx_Done,
   input  logic [7:0]        i_Rx_Byte,
   output logic              o_Rd_Valid,
   output logic [7:0]        o_Rd_Data,
   input  logic              i_Rd_Ready,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Full,
   output logic              o_Empty,
   output logic              o_Almost_Full,
   output logic              o_Overrun,
   input  logic              i_Clr_Overrun
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic              pop, push_ok, drop;

   assign o_Empty       = (count == '0);
   assign o_Full        = (count == DEPTH_C);
   assign o_Almost_Full = (count >= AF_C);
   assign o_Rd_Valid    = !o_Empty;
   assign o_Count       = count;
   assign o_Rd_Data     = o_Rd_Valid ? mem[rd_ptr] : 8'h00;

   // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
   assign pop     = o_Rd_Valid & i_Rd_Ready;
   assign push_ok = i_Rx_Done & (!o_Full | pop);
   assign drop    = i_Rx_Done & o_Full & !pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= i_Rx_Byte;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         o_Overrun <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Setting takes priority over a same-cycle clear so no drop goes unreported.
         if (drop)               o_Overrun <= 1'b1;
         else if (i_Clr_Overrun) o_Overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, ordering, fill/overrun, full push+pop,
// overrun clear, mid-stream reset and a scoreboarded wrap run.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rd_ready = 1'b0;
   logic       clr = 1'b0;
   logic       rd_valid, full, empty, afull, ovr;
   logic [7:0] rd_data;
   logic [4:0] count;

   int n_cmp = 0;
   int n_err = 0;

   uart_rx_fifo #(.ADDR_W(4), .AF_LEVEL(12)) dut (
      .clk(clk), .reset_n(reset_n), .i_Rx_Done(rx_done), .i_Rx_Byte(rx_byte),
      .o_Rd_Valid(rd_valid), .o_Rd_Data(rd_data), .i_Rd_Ready(rd_ready),
      .o_Count(count), .o_Full(full), .o_Empty(empty), .o_Almost_Full(afull),
      .o_Overrun(ovr), .i_Clr_Overrun(clr)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_done = 1'b1; rx_byte = b;
      step();
      rx_done = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; rx_done = 1'b1; rx_byte = 8'h55;
      step();
      rx_done = 1'b0;
      step();
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", rd_data); end
      n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr got %b exp 0", ovr); end
      n_cmp++; if (full !== 1'b0 || afull !== 1'b0) begin n_err++; $display("FAIL reset_flags got full=%b af=%b exp 0 0", full, afull); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_order();
      logic [7:0] exp [3];
      exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
      rd_ready = 1'b0;
      push(8'hA5);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_err++; $display("FAIL order_first got v=%b d=%h exp v=1 d=a5", rd_valid, rd_data); end
      push(8'h3C);
      push(8'hFF);
      n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL order_count got %0d exp 3", count); end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rd_data !== exp[i]) begin n_err++; $display("FAIL order_pop%0d got %h exp %h", i, rd_data, exp[i]); end
         step();
      end
      rd_ready = 1'b0;
      n_cmp++; if (empty !== 1'b1 || rd_data !== 8'h00) begin n_err++; $display("FAIL order_empty got e=%b d=%h exp e=1 d=00", empty, rd_data); end
   endtask

   task automatic test_fill();
      rd_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         n_cmp++; if (count !== 5'(i+1)) begin n_err++; $display("FAIL fill_count%0d got %0d exp %0d", i, count, i+1); end
         n_cmp++; if (afull !== ((i+1) >= 12)) begin n_err++; $display("FAIL fill_af%0d got %b exp %b", i, afull, ((i+1) >= 12)); end
      end
      n_cmp++; if (full !== 1'b1 || ovr !== 1'b0) begin n_err++; $display("FAIL fill_full got full=%b ovr=%b exp 1 0", full, ovr); end
      push(8'hEE);
      n_cmp++; if (ovr !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL fill_overrun got ovr=%b cnt=%0d exp 1 16", ovr, count); end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (rd_data !== 8'(i)) begin n_err++; $display("FAIL fill_drain%0d got %h exp %h", i, rd_data, 8'(i)); end
         step();
      end
      rd_ready = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained got empty=%b exp 1", empty); end
   endtask

   task automatic test_ovr_clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL clr_alone got %b exp 0", ovr); end
      for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
      n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL clr_reset_ovr got %b exp 1", ovr); end
      clr = 1'b1;
      step();
      n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL clr_second got %b exp 0", ovr); end
      rx_done = 1'b1; rx_byte = 8'h99;
      step();
      rx_done = 1'b0; clr = 1'b0;
      n_cmp++; if (ovr !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL clr_set_wins got ovr=%b cnt=%0d exp 1 16", ovr, count); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL clr_final got %b exp 0", ovr); end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) step();
      rd_ready = 1'b0;
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < 16; i++) push(8'(i));
      rd_ready = 1'b1; rx_done = 1'b1; rx_byte = 8'h77;
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL fpp_head got %h exp 00", rd_data); end
      step();
      rx_done = 1'b0; rd_ready = 1'b0;
      n_cmp++; if (count !== 5'd16 || ovr !== 1'b0) begin n_err++; $display("FAIL fpp_state got cnt=%0d ovr=%b exp 16 0", count, ovr); end
      rd_ready = 1'b1;
      for (int i = 1; i < 17; i++) begin
         n_cmp++;
         if (rd_data !== ((i == 16) ? 8'h77 : 8'(i))) begin
            n_err++; $display("FAIL fpp_drain%0d got %h exp %h", i, rd_data, ((i == 16) ? 8'h77 : 8'(i)));
         end
         step();
      end
      rd_ready = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty got %b exp 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
      n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL rmid_pre got %0d exp 5", count); end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin n_err++; $display("FAIL rmid_post got cnt=%0d e=%b d=%h exp 0 1 00", count, empty, rd_data); end
   endtask

   task automatic test_wrap();
      logic [7:0] q [$];
      logic       p;
      for (int c = 0; c < 40; c++) begin
         rx_done  = 1'($urandom_range(0, 1));
         rx_byte  = 8'($urandom);
         rd_ready = 1'($urandom_range(0, 1));
         n_cmp++; if (count !== 5'(q.size())) begin n_err++; $display("FAIL wrap_count%0d got %0d exp %0d", c, count, q.size()); end
         n_cmp++;
         if (rd_data !== ((q.size() != 0) ? q[0] : 8'h00)) begin
            n_err++; $display("FAIL wrap_data%0d got %h exp %h", c, rd_data, ((q.size() != 0) ? q[0] : 8'h00));
         end
         p = (q.size() != 0) && rd_ready;
         if (rx_done && (q.size() < 16 || p)) q.push_back(rx_byte);
         if (p) void'(q.pop_front());
         step();
      end
      rx_done = 1'b0; rd_ready = 1'b1;
      while (q.size() != 0) begin
         n_cmp++; if (rd_data !== q[0]) begin n_err++; $display("FAIL wrap_drain got %h exp %h", rd_data, q[0]); end
         void'(q.pop_front());
         step();
      end
      rd_ready = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b exp 1", empty); end
   endtask

   initial begin
      #1;
      test_reset();
      test_order();
      test_fill();
      test_ovr_clear();
      test_full_pushpop();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
